// File: rtl/pvl_pkg.sv
// Shared types for the price/volume book: query modes and the pipeline record.
// Record fields are sized for the largest supported configuration; the top slices them.
package pvl_pkg;

    typedef enum logic {
        MODE_LOOKUP  = 1'b0,
        MODE_CONSUME = 1'b1
    } pvl_mode_t;

    localparam int SYM_MAX_W = 16;
    localparam int LVL_MAX_W = 3;
    localparam int VOL_MAX_W = 64;

    typedef struct packed {
        logic                 valid;
        pvl_mode_t            mode;
        logic [SYM_MAX_W-1:0] symbol;
        logic [VOL_MAX_W-1:0] qty;
        logic [LVL_MAX_W-1:0] level;
        logic                 hit;
        logic [VOL_MAX_W-1:0] volume;
        logic [VOL_MAX_W-1:0] filled;
    } pvl_rec_t;

    function automatic int lvl_width(input int num_levels);
        return (num_levels > 1) ? $clog2(num_levels) : 1;
    endfunction

endpackage

// File: rtl/pvl_level_match.sv
// Combinational level matcher: price compare across all levels, lowest-index
// priority, and the fill amount for a consume (never more than the level holds).
module pvl_level_match
    import pvl_pkg::*;
#(
    parameter int  NUM_LEVELS = 3,
    parameter int  PRICE_W    = 32,
    parameter int  VOL_W      = 32,
    localparam int LVL_W      = lvl_width(NUM_LEVELS)
) (
    input  logic [NUM_LEVELS*PRICE_W-1:0] level_price,
    input  logic [NUM_LEVELS*VOL_W-1:0]   level_volume,
    input  logic [NUM_LEVELS-1:0]         level_valid,
    input  logic [PRICE_W-1:0]            query_price,
    input  logic [VOL_W-1:0]              query_qty,
    input  pvl_mode_t                     query_mode,
    output logic                          hit,
    output logic [LVL_W-1:0]              level,
    output logic [VOL_W-1:0]              volume,
    output logic [VOL_W-1:0]              filled
);

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        hit    = 1'b0;
        level  = '0;
        volume = '0;
        filled = '0;
        // Scan high to low so the lowest matching level is the last one to land.
        for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
            if (level_valid[i] && level_price[i*PRICE_W +: PRICE_W] == query_price) begin
                hit    = 1'b1;
                level  = LVL_W'(i);
                volume = level_volume[i*VOL_W +: VOL_W];
            end
        end
        if (hit && query_mode == MODE_CONSUME) begin
            filled = (query_qty < volume) ? query_qty : volume;
        end
    end

endmodule

// File: rtl/price_volume_book.sv
// Per-symbol price/volume book with a 2-cycle lookup/consume pipeline,
// single shared write port (config beats consume writeback) and RAW forwarding.
module price_volume_book
    import pvl_pkg::*;
#(
    parameter int  NUM_SYMBOLS = 256,
    parameter int  NUM_LEVELS  = 3,
    parameter int  PRICE_W     = 32,
    parameter int  VOL_W       = 32,
    localparam int SYM_W       = $clog2(NUM_SYMBOLS),
    localparam int LVL_W       = lvl_width(NUM_LEVELS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_mode,
    input  logic [SYM_W-1:0]              in_symbol_index,
    input  logic [PRICE_W-1:0]            in_price,
    input  logic [VOL_W-1:0]              in_qty,
    input  logic                          in_config_valid,
    input  logic [SYM_W-1:0]              in_config_symbol_index,
    input  logic [NUM_LEVELS-1:0]         in_config_level_en,
    input  logic [NUM_LEVELS*PRICE_W-1:0] in_config_price,
    input  logic [NUM_LEVELS*VOL_W-1:0]   in_config_volume,
    output logic                          out_valid,
    output logic                          out_hit,
    output logic [LVL_W-1:0]              out_level,
    output logic [VOL_W-1:0]              out_volume,
    output logic [VOL_W-1:0]              out_filled,
    output logic                          out_collision
);

    logic                                  accept;
    pvl_rec_t                              s1, s1_next, s2, s2_next;
    logic [PRICE_W-1:0]                    s1_price;
    logic [SYM_W-1:0]                      s1_symbol;

    logic [NUM_SYMBOLS-1:0][NUM_LEVELS-1:0] level_valid;

    logic                                  consume_wb;
    logic [VOL_W-1:0]                      wb_volume;
    logic [SYM_W-1:0]                      wr_sym;
    logic [NUM_LEVELS-1:0]                 price_we;
    logic [NUM_LEVELS-1:0]                 vol_we;
    logic [NUM_LEVELS*VOL_W-1:0]           wr_vol;
    logic [NUM_LEVELS-1:0]                 wr_vbit;

    logic [NUM_LEVELS*PRICE_W-1:0]         eff_price;
    logic [NUM_LEVELS*VOL_W-1:0]           eff_volume;
    logic [NUM_LEVELS-1:0]                 eff_valid;
    logic                                  fwd_sym;

    logic                                  m_hit;
    logic [LVL_W-1:0]                      m_level;
    logic [VOL_W-1:0]                      m_volume;
    logic [VOL_W-1:0]                      m_filled;

    assign in_ready   = !in_config_valid;
    assign accept     = in_valid && in_ready;
    assign s1_symbol  = s1.symbol[SYM_W-1:0];
    assign consume_wb = s2.valid && s2.mode == MODE_CONSUME && s2.hit;
    assign wb_volume  = s2.volume[VOL_W-1:0] - s2.filled[VOL_W-1:0];

    // Single write port: a config write always wins; the consume writeback is dropped.
    always_comb begin
        wr_sym   = in_config_symbol_index;
        price_we = '0;
        vol_we   = '0;
        wr_vol   = in_config_volume;
        wr_vbit  = '0;
        if (in_config_valid) begin
            price_we = in_config_level_en;
            vol_we   = in_config_level_en;
            for (int i = 0; i < NUM_LEVELS; i++) begin
                wr_vbit[i] = |in_config_volume[i*VOL_W +: VOL_W];
            end
        end else if (consume_wb) begin
            wr_sym  = s2.symbol[SYM_W-1:0];
            vol_we  = NUM_LEVELS'(1) << s2.level[LVL_W-1:0];
            wr_vol  = {NUM_LEVELS{wb_volume}};
            wr_vbit = {NUM_LEVELS{wb_volume != '0}};
        end
    end

    assign fwd_sym = (wr_sym == s1_symbol);

    for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_level
        logic [PRICE_W-1:0] price_mem [NUM_SYMBOLS];
        logic [VOL_W-1:0]   vol_mem   [NUM_SYMBOLS];
        logic [PRICE_W-1:0] rd_price;
        logic [VOL_W-1:0]   rd_volume;

        // NOTE: RAM arrays and their read registers have no reset; only level_valid qualifies them.
        always_ff @(posedge clk) begin
            if (price_we[g]) price_mem[wr_sym] <= in_config_price[g*PRICE_W +: PRICE_W];
            if (vol_we[g])   vol_mem[wr_sym]   <= wr_vol[g*VOL_W +: VOL_W];
            if (accept) begin
                rd_price  <= (price_we[g] && wr_sym == in_symbol_index)
                             ? in_config_price[g*PRICE_W +: PRICE_W] : price_mem[in_symbol_index];
                rd_volume <= (vol_we[g] && wr_sym == in_symbol_index)
                             ? wr_vol[g*VOL_W +: VOL_W] : vol_mem[in_symbol_index];
            end
        end

        // Stage-1 view: storage merged with the write committing at the coming edge.
        assign eff_price[g*PRICE_W +: PRICE_W] = (price_we[g] && fwd_sym)
                                                 ? in_config_price[g*PRICE_W +: PRICE_W] : rd_price;
        assign eff_volume[g*VOL_W +: VOL_W]    = (vol_we[g] && fwd_sym)
                                                 ? wr_vol[g*VOL_W +: VOL_W] : rd_volume;
        assign eff_valid[g]                    = (vol_we[g] && fwd_sym)
                                                 ? wr_vbit[g] : level_valid[s1_symbol][g];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_LEVELS; i++) begin
                if (vol_we[i]) level_valid[wr_sym][i] <= wr_vbit[i];
            end
        end
    end

    pvl_level_match #(
        .NUM_LEVELS (NUM_LEVELS),
        .PRICE_W    (PRICE_W),
        .VOL_W      (VOL_W)
    ) u_match (
        .level_price  (eff_price),
        .level_volume (eff_volume),
        .level_valid  (eff_valid),
        .query_price  (s1_price),
        .query_qty    (s1.qty[VOL_W-1:0]),
        .query_mode   (s1.mode),
        .hit          (m_hit),
        .level        (m_level),
        .volume       (m_volume),
        .filled       (m_filled)
    );

    always_comb begin
        s1_next        = '0;
        s1_next.valid  = accept;
        s1_next.mode   = pvl_mode_t'(in_mode);
        s1_next.symbol = SYM_MAX_W'(in_symbol_index);
        s1_next.qty    = VOL_MAX_W'(in_qty);
    end

    always_comb begin
        s2_next = '0;
        if (s1.valid) begin
            s2_next.valid  = 1'b1;
            s2_next.mode   = s1.mode;
            s2_next.symbol = s1.symbol;
            s2_next.qty    = s1.qty;
            s2_next.hit    = m_hit;
            s2_next.level  = LVL_MAX_W'(m_level);
            s2_next.volume = VOL_MAX_W'(m_volume);
            s2_next.filled = VOL_MAX_W'(m_filled);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1            <= '0;
            s1_price      <= '0;
            s2            <= '0;
            out_valid     <= 1'b0;
            out_hit       <= 1'b0;
            out_level     <= '0;
            out_volume    <= '0;
            out_filled    <= '0;
            out_collision <= 1'b0;
        end else begin
            s1            <= s1_next;
            s1_price      <= in_price;
            s2            <= s2_next;
            out_valid     <= s2.valid;
            out_hit       <= s2.hit;
            out_level     <= s2.level[LVL_W-1:0];
            out_volume    <= s2.volume[VOL_W-1:0];
            out_filled    <= s2.filled[VOL_W-1:0];
            out_collision <= consume_wb && in_config_valid;
        end
    end

    // Record fields beyond this configuration's widths are intentionally left unread.
    logic unused_rec_bits;
    assign unused_rec_bits = ^{s1, s2};

endmodule

// File: tb/tb_price_volume_book.sv
// Directed, table-driven bench for price_volume_book with hand-written
// sequences for config back-pressure, write collision and mid-pipeline reset.
module tb_price_volume_book;

    localparam int SW = 8;
    localparam int NL = 3;
    localparam int PW = 32;
    localparam int VW = 32;
    localparam logic L = 1'b0;
    localparam logic C = 1'b1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [SW-1:0]    in_symbol_index;
    logic [PW-1:0]    in_price;
    logic [VW-1:0]    in_qty;
    logic             in_config_valid;
    logic [SW-1:0]    in_config_symbol_index;
    logic [NL-1:0]    in_config_level_en;
    logic [NL*PW-1:0] in_config_price;
    logic [NL*VW-1:0] in_config_volume;
    logic             out_valid;
    logic             out_hit;
    logic [1:0]       out_level;
    logic [VW-1:0]    out_volume;
    logic [VW-1:0]    out_filled;
    logic             out_collision;

    price_volume_book dut (
        .clk                    (clk),
        .reset                  (reset),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .in_mode                (in_mode),
        .in_symbol_index        (in_symbol_index),
        .in_price               (in_price),
        .in_qty                 (in_qty),
        .in_config_valid        (in_config_valid),
        .in_config_symbol_index (in_config_symbol_index),
        .in_config_level_en     (in_config_level_en),
        .in_config_price        (in_config_price),
        .in_config_volume       (in_config_volume),
        .out_valid              (out_valid),
        .out_hit                (out_hit),
        .out_level              (out_level),
        .out_volume             (out_volume),
        .out_filled             (out_filled),
        .out_collision          (out_collision)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic          mode;
        logic [SW-1:0] sym;
        logic [PW-1:0] price;
        logic [VW-1:0] qty;
        logic          hit;
        logic [1:0]    level;
        logic [VW-1:0] volume;
        logic [VW-1:0] filled;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input logic mode, input int sym, input int price, input int qty,
                                input logic hit, input int level, input int volume, input int filled);
        vec_t v;
        v.mode   = mode;
        v.sym    = SW'(sym);
        v.price  = PW'(price);
        v.qty    = VW'(qty);
        v.hit    = hit;
        v.level  = 2'(level);
        v.volume = VW'(volume);
        v.filled = VW'(filled);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_resp(input string name, input logic hit, input logic [1:0] level,
                              input logic [VW-1:0] volume, input logic [VW-1:0] filled,
                              input logic coll);
        check({name, ".valid"},     64'(out_valid),     64'd1);
        check({name, ".hit"},       64'(out_hit),       64'(hit));
        check({name, ".level"},     64'(out_level),     64'(level));
        check({name, ".volume"},    64'(out_volume),    64'(volume));
        check({name, ".filled"},    64'(out_filled),    64'(filled));
        check({name, ".collision"}, 64'(out_collision), 64'(coll));
    endtask

    task automatic check_idle(input string name);
        check({name, ".valid"}, 64'(out_valid), 64'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_query(input logic mode, input logic [SW-1:0] sym,
                               input logic [PW-1:0] price, input logic [VW-1:0] qty);
        in_valid        = 1'b1;
        in_mode         = mode;
        in_symbol_index = sym;
        in_price        = price;
        in_qty          = qty;
    endtask

    task automatic cfg(input logic [SW-1:0] sym, input logic [NL-1:0] en,
                       input logic [NL*PW-1:0] prices, input logic [NL*VW-1:0] vols);
        in_config_valid        = 1'b1;
        in_config_symbol_index = sym;
        in_config_level_en     = en;
        in_config_price        = prices;
        in_config_volume       = vols;
        step();
        in_config_valid        = 1'b0;
    endtask

    // Issue vecs[lo..hi] back-to-back; each response appears two edges after issue.
    task automatic run_table(input int lo, input int hi);
        for (int s = lo; s <= hi + 2; s++) begin
            if (s <= hi) drive_query(vecs[s].mode, vecs[s].sym, vecs[s].price, vecs[s].qty);
            else in_valid = 1'b0;
            step();
            if (s >= lo + 2) begin
                check_resp($sformatf("vec%0d", s - 2), vecs[s-2].hit, vecs[s-2].level,
                           vecs[s-2].volume, vecs[s-2].filled, 1'b0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Symbol 0: (100,50) (110,10) (120,30)
        vecs[0]  = mk(L, 0, 100, 55, 1'b1, 0, 50, 0);
        vecs[1]  = mk(L, 0, 110, 0,  1'b1, 1, 10, 0);
        vecs[2]  = mk(L, 0, 121, 0,  1'b0, 0, 0,  0);
        vecs[3]  = mk(C, 0, 100, 20, 1'b1, 0, 50, 20);
        vecs[4]  = mk(C, 0, 100, 40, 1'b1, 0, 30, 30);
        vecs[5]  = mk(L, 0, 100, 0,  1'b0, 0, 0,  0);
        vecs[6]  = mk(C, 0, 110, 0,  1'b1, 1, 10, 0);
        vecs[7]  = mk(C, 0, 110, 3,  1'b1, 1, 10, 3);
        vecs[8]  = mk(L, 0, 110, 0,  1'b1, 1, 7,  0);
        // Symbol 2: duplicate price 200, level 0 configured with volume 0
        vecs[9]  = mk(L, 2, 200, 0,  1'b1, 1, 5,  0);
        vecs[10] = mk(C, 2, 200, 9,  1'b1, 1, 5,  5);
        vecs[11] = mk(L, 2, 200, 0,  1'b1, 2, 6,  0);
        // Symbol 1 after a partial-enable rewrite of level 1
        vecs[12] = mk(L, 1, 500, 0,  1'b1, 1, 7,  0);
        vecs[13] = mk(L, 1, 300, 0,  1'b1, 0, 1,  0);
        vecs[14] = mk(L, 1, 600, 0,  1'b1, 2, 3,  0);
        vecs[15] = mk(L, 1, 400, 0,  1'b0, 0, 0,  0);

        reset                  = 1'b1;
        in_valid               = 1'b0;
        in_mode                = L;
        in_symbol_index        = '0;
        in_price               = '0;
        in_qty                 = '0;
        in_config_valid        = 1'b0;
        in_config_symbol_index = '0;
        in_config_level_en     = '0;
        in_config_price        = '0;
        in_config_volume       = '0;
        step();
        step();
        check("rst.valid",     64'(out_valid),     64'd0);
        check("rst.hit",       64'(out_hit),       64'd0);
        check("rst.volume",    64'(out_volume),    64'd0);
        check("rst.collision", 64'(out_collision), 64'd0);
        check("rst.in_ready",  64'(in_ready),      64'd1);
        reset = 1'b0;
        step();

        cfg(8'd0, 3'b111, {32'd120, 32'd110, 32'd100}, {32'd30, 32'd10, 32'd50});
        run_table(0, 2);
        run_table(3, 8);

        cfg(8'd2, 3'b111, {32'd200, 32'd200, 32'd200}, {32'd6, 32'd5, 32'd0});
        run_table(9, 11);

        cfg(8'd1, 3'b111, {32'd600, 32'd400, 32'd300}, {32'd3, 32'd2, 32'd1});
        cfg(8'd1, 3'b010, {32'd999, 32'd500, 32'd999}, {32'd999, 32'd7, 32'd999});
        run_table(12, 15);

        // Config held 3 cycles while a query waits on symbol 3.
        drive_query(L, 8'd3, 32'd700, 32'd0);
        in_config_valid        = 1'b1;
        in_config_symbol_index = 8'd3;
        in_config_level_en     = 3'b001;
        in_config_price        = {32'd0, 32'd0, 32'd700};
        in_config_volume       = {32'd0, 32'd0, 32'd44};
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("hold%0d.in_ready", k), 64'(in_ready), 64'd0);
            step();
            check_idle($sformatf("hold%0d.out", k));
        end
        in_config_valid = 1'b0;
        #1;
        check("release.in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check_idle("release.t0");
        step();
        check_idle("release.t1");
        step();
        check_resp("release.resp", 1'b1, 2'd0, 32'd44, 32'd0, 1'b0);
        step();
        check_idle("release.after");

        // Consume writeback collides with a config write two cycles later.
        drive_query(C, 8'd0, 32'd120, 32'd5);
        step();
        in_valid = 1'b0;
        step();
        in_config_valid        = 1'b1;
        in_config_symbol_index = 8'd0;
        in_config_level_en     = 3'b100;
        in_config_price        = {32'd120, 32'd0, 32'd0};
        in_config_volume       = {32'd99, 32'd0, 32'd0};
        step();
        in_config_valid = 1'b0;
        check_resp("collide", 1'b1, 2'd2, 32'd30, 32'd5, 1'b1);
        drive_query(L, 8'd0, 32'd120, 32'd0);
        step();
        drive_query(L, 8'd0, 32'd110, 32'd0);
        step();
        in_valid = 1'b0;
        step();
        check_resp("after_collide.lvl2", 1'b1, 2'd2, 32'd99, 32'd0, 1'b0);
        step();
        check_resp("after_collide.lvl1", 1'b1, 2'd1, 32'd7, 32'd0, 1'b0);

        // Reset with two queries in flight.
        drive_query(L, 8'd0, 32'd110, 32'd0);
        step();
        drive_query(L, 8'd0, 32'd110, 32'd0);
        step();
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        check_idle("midrst.a");
        step();
        check_idle("midrst.b");
        reset = 1'b0;
        step();
        check_idle("midrst.c");
        step();
        check_idle("midrst.d");
        drive_query(L, 8'd0, 32'd110, 32'd0);
        step();
        in_valid = 1'b0;
        step();
        step();
        check_resp("post_rst", 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/price_volume_book.md
# price_volume_book

Parametrised successor to the 3-level price/volume lookup. It holds up to NUM_LEVELS price/volume pairs per symbol and answers lookup queries through a fixed 2-cycle pipeline. New over the previous generation:
- per-level config write enables;
- a consume mode that decrements the matched volume in place;
- read-after-write forwarding;
- an explicit miss response.

It sits between the order-entry decoder (queries) and the host config path (book updates).

## Interface
Parameters:
- NUM_SYMBOLS, 256: entries; index width SYM_W = $clog2(NUM_SYMBOLS).
- NUM_LEVELS, 3: price levels per symbol, 1..8; level width LVL_W = max(1,$clog2(NUM_LEVELS)).
- PRICE_W, 32: price width.
- VOL_W, 32: volume and quantity width.

Ports:
- clk, in, 1: single clock; all logic on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- in_valid, in, 1: query strobe; accepted when in_valid && in_ready.
- in_ready, out, 1: equals !in_config_valid. Config has priority.
- in_mode, in, 1: 0 = LOOKUP, 1 = CONSUME.
- in_symbol_index, in, SYM_W: symbol queried.
- in_price, in, PRICE_W: price to match.
- in_qty, in, VOL_W: amount to consume; ignored in LOOKUP.
- in_config_valid, in, 1: config write strobe; always accepted.
- in_config_symbol_index, in, SYM_W: entry written.
- in_config_level_en, in, NUM_LEVELS: per-level write enable.
- in_config_price, in, NUM_LEVELS*PRICE_W: level i occupies bits [i*PRICE_W +: PRICE_W].
- in_config_volume, in, NUM_LEVELS*VOL_W: level i occupies bits [i*VOL_W +: VOL_W].
- out_valid, out, 1: one pulse per accepted query.
- out_hit, out, 1: a level matched.
- out_level, out, LVL_W: index of the matched level; 0 on miss.
- out_volume, out, VOL_W: matched volume before consumption; 0 on miss.
- out_filled, out, VOL_W: min(in_qty, volume) in CONSUME; 0 in LOOKUP and on miss.
- out_collision, out, 1: this CONSUME's writeback was dropped because a config write occurred in the same cycle.

## Operation
- Storage per symbol and level: price RAM, volume RAM, and a level_valid flop.
  - level_valid bits are the only state cleared by reset. RAM contents are don't-care after reset.
- Config write (1 cycle): for each i with in_config_level_en[i] = 1:
  - price[i] and volume[i] are written;
  - level_valid[i] is set to (volume[i] != 0).
  - Levels with en = 0 are untouched.
- Match rule: level i matches if level_valid[i] and price[i] == in_price. The lowest matching index wins; duplicate prices resolve to the lowest level.
- LOOKUP: reports the matched entry; storage is unchanged.
- CONSUME on a hit:
  - filled = min(in_qty, vol);
  - vol - filled is written back to the matched level;
  - if the result is 0, that level's level_valid is cleared.
  - There is no underflow; the subtraction saturates at 0.
- CONSUME on a miss: no write.
- A miss produces out_valid = 1 with out_hit = 0 and all data outputs 0.
- Write port arbitration: one write per cycle.
  - A config write and a stage-2 consume writeback can coincide. The config write wins and the consume writeback is discarded, for all levels and regardless of symbol or enables.
  - out_collision = 1 on that query's response.
  - out_volume and out_filled still report the values computed before the drop.
- Forwarding: a query in stage 1 compares against the current storage value merged with any write to the same symbol committing at the same edge. Back-to-back CONSUMEs to the same symbol therefore see each other's results.

## Timing
- Stage 0, edge T: query accepted; synchronous RAM read issued.
- Stage 1, edge T+1: read data and forwarded data compared; match and fill computed.
- Stage 2, edge T+2: outputs registered; CONSUME writeback committed.
- out_valid is high for the cycle following edge T+2. Latency is 2 cycles. Throughput is 1 query per cycle while in_ready = 1.
- Config write commits at the edge it is sampled. A query accepted at the next edge sees the new values.
- While in_config_valid = 1, in_ready = 0 and in_valid is ignored. Queries already in flight complete.
- Reset values:
  - all outputs 0, except in_ready = !in_config_valid;
  - pipeline valids 0;
  - all level_valid bits 0.
- Reset asserted mid-pipeline: in-flight queries are dropped with no out_valid and no writeback. The first query after reset deassertion misses.

## Structure
- Package pvl_pkg holds:
  - mode constants MODE_LOOKUP = 0 and MODE_CONSUME = 1;
  - the stage-1 and stage-2 pipeline record struct: valid, mode, symbol, qty, level, hit, volume, filled.
- Sub-module pvl_level_match: combinational, NUM_LEVELS-wide price compare, lowest-index priority encoder, and saturating fill computation. It is instantiated once in stage 1.

## Test plan
- Reset, then config symbol 0 with prices (100,110,120), volumes (50,10,30), en = 111. LOOKUP (0,100), (0,110), (0,121) back-to-back -> outputs (hit, 0, 50), (hit, 1, 10), miss with all data 0, on 3 consecutive cycles.
- CONSUME (0,100,qty 20), then CONSUME (0,100,qty 40) on the next cycle -> out_filled 20 then 30 (forwarded volume 30). LOOKUP (0,100) -> miss, because level_valid was cleared.
- Config symbol 1 with en = 010, price 500, volume 7 -> levels 0 and 2 of symbol 1 unchanged. LOOKUP (1,500) -> level 1, volume 7.
- Config asserted for 3 cycles while in_valid is held -> in_ready = 0 for those 3 cycles. Queries are held off, none is lost, and the first query after release sees the new config.
- Issue CONSUME (0,120,qty 5), then assert config on symbol 0 exactly 2 cycles later -> out_collision = 1, out_filled = 5. Stored volume equals the config value.
- Assert reset with 2 queries in flight -> no out_valid pulses. After release, LOOKUP (0,110) -> miss.
